// File: rtl/fano_sym_reader.sv
`default_nettype none
// ============================================================================
// Module   : fano_sym_reader
// Purpose  : Frame reader between the soft-symbol FIFO and the Fano decoder.
//            Pulls rate-1/2 soft-symbol pairs from a non-FWFT FIFO with a
//            one-cycle read latency. For each pair it computes the four branch
//            metrics and queues them in a 2-entry buffer. The decoder takes
//            entries over a valid/ready handshake, together with the pair
//            index and a last-of-frame flag.
// Ports    : Clk, Rst (async, active-low)
//            Start/Busy/Done  - frame control (FRAME_LEN pairs per frame)
//            rdData/rdRe/rdEmpty - FIFO read port
//            oValid/oReady/oBm/oIdx/oLast - decoder-side handshake
// Config   : FANO_SYM_READER_SAT_EN defined   -> metrics clamp to METRIC_W
//            FANO_SYM_READER_SAT_EN undefined -> metrics wrap to METRIC_W LSBs
// Revision : 1.0 - initial release
// ============================================================================
module fano_sym_reader #(
    parameter int SOFT_W    = 3,
    parameter int METRIC_W  = 6,
    parameter int BIAS      = 4,
    parameter int FRAME_LEN = 64,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    input  logic [2*SOFT_W-1:0]     rdData,
    output logic                    rdRe,
    input  logic                    rdEmpty,
    output logic                    oValid,
    input  logic                    oReady,
    output logic [4*METRIC_W-1:0]   oBm,
    output logic [IDX_W-1:0]        oIdx,
    output logic                    oLast
);

    // Request counter must be able to hold FRAME_LEN itself.
    localparam int                  c_CNT_W    = IDX_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FRAME    = c_CNT_W'(FRAME_LEN);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [IDX_W-1:0]    c_LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]    c_IDX_ONE  = IDX_W'(1);

    // Arithmetic width of the metric datapath. Wrapping to METRIC_W bits
    // gives the same result as computing at 32 bits and truncating, so the
    // wrap build works directly at METRIC_W; the clamp build needs the full
    // range to detect overflow.
`ifdef FANO_SYM_READER_SAT_EN
    localparam int c_AW = 32;
    localparam logic signed [31:0]       c_HI   = 32'((1 << (METRIC_W - 1)) - 1);
    localparam logic signed [31:0]       c_LO   = -c_HI - 32'sd1;
    localparam logic [METRIC_W-1:0]      c_HI_M = METRIC_W'(c_HI);
    localparam logic [METRIC_W-1:0]      c_LO_M = METRIC_W'(c_LO);
`else
    localparam int c_AW = METRIC_W;
`endif
    localparam logic signed [c_AW-1:0] c_MAX  = c_AW'((1 << SOFT_W) - 1);
    localparam logic signed [c_AW-1:0] c_BIAS = c_AW'(BIAS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_req_cnt;
    logic [IDX_W-1:0]       r_acc_cnt;
    logic [IDX_W-1:0]       r_wr_idx;
    logic                   r_infl;
    logic [1:0]             r_occ;
    logic                   r_head;
    logic                   r_tail;
    logic [4*METRIC_W-1:0]  r_bm_mem  [2];
    logic [IDX_W-1:0]       r_idx_mem [2];
    logic [1:0]             r_last_mem;

    logic                   w_pop;
    logic                   w_push;
    logic [2:0]             w_occ_after;
    logic [SOFT_W-1:0]      w_sym0;
    logic [SOFT_W-1:0]      w_sym1;
    logic signed [c_AW-1:0] w_s0;
    logic signed [c_AW-1:0] w_s1;
    logic [4*METRIC_W-1:0]  w_bm;

    // ------------------------------------------------------------------
    // Handshake and read issue
    // ------------------------------------------------------------------
    assign oValid = (r_occ != 2'd0);
    assign w_pop  = oValid & oReady;
    assign w_push = r_infl;           // FIFO data is valid the cycle after rdRe
    assign oBm    = r_bm_mem[r_head];
    assign oIdx   = r_idx_mem[r_head];
    assign oLast  = r_last_mem[r_head];
    assign Busy   = (r_state != S_IDLE);
    assign Done   = w_pop & (r_acc_cnt == c_LAST_IDX);

    // Occupancy at the end of this cycle, counting the read already in
    // flight. A new read is issued only if its data will still fit.
    assign w_occ_after = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};

    assign rdRe = (r_state == S_RUN) & ~rdEmpty & (r_req_cnt < c_FRAME)
                & (w_occ_after < 3'd2);

    // ------------------------------------------------------------------
    // Branch metrics: bm[k] = BIAS - dist(sym0,c0) - dist(sym1,c1),
    // k = {c0,c1}; dist(s,b) = b ? MAX-s : s (offset-binary soft symbols)
    // ------------------------------------------------------------------
    assign w_sym0 = rdData[2*SOFT_W-1:SOFT_W];
    assign w_sym1 = rdData[SOFT_W-1:0];
    assign w_s0   = c_AW'(w_sym0);
    assign w_s1   = c_AW'(w_sym1);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_bm
            localparam bit c_C0 = ((k / 2) % 2) == 1;
            localparam bit c_C1 = (k % 2) == 1;

            logic signed [c_AW-1:0] w_d0;
            logic signed [c_AW-1:0] w_d1;
            logic signed [c_AW-1:0] w_full;

            assign w_d0   = c_C0 ? (c_MAX - w_s0) : w_s0;
            assign w_d1   = c_C1 ? (c_MAX - w_s1) : w_s1;
            assign w_full = c_BIAS - w_d0 - w_d1;
`ifdef FANO_SYM_READER_SAT_EN
            assign w_bm[k*METRIC_W +: METRIC_W] =
                (w_full > c_HI) ? c_HI_M :
                (w_full < c_LO) ? c_LO_M : w_full[METRIC_W-1:0];
`else
            assign w_bm[k*METRIC_W +: METRIC_W] = w_full;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM, counters and 2-entry output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_req_cnt  <= '0;
            r_acc_cnt  <= '0;
            r_wr_idx   <= '0;
            r_infl     <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_last_mem <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_bm_mem[i]  <= '0;
                r_idx_mem[i] <= '0;
            end
        end else begin
            r_infl <= rdRe;

            if (rdRe) begin
                r_req_cnt <= r_req_cnt + c_CNT_ONE;
            end

            if (w_push) begin
                r_bm_mem[r_tail]   <= w_bm;
                r_idx_mem[r_tail]  <= r_wr_idx;
                r_last_mem[r_tail] <= (r_wr_idx == c_LAST_IDX);
                r_tail             <= ~r_tail;
                r_wr_idx           <= r_wr_idx + c_IDX_ONE;
            end

            if (w_pop) begin
                r_head    <= ~r_head;
                r_acc_cnt <= r_acc_cnt + c_IDX_ONE;
            end

            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
                S_IDLE: begin
                    r_req_cnt <= '0;
                    r_acc_cnt <= '0;
                    r_wr_idx  <= '0;
                    if (Start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (Done) begin
                        r_state <= S_IDLE;
                    end else if (r_req_cnt == c_FRAME) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (Done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fano_sym_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fano_sym_reader
// Purpose  : Self-checking bench for fano_sym_reader. A FIFO model feeds the
//            main instance; every read pushes the expected entry onto a
//            scoreboard queue, which is popped on each accepted output.
//            A second instance with a narrow metric width checks the
//            clamp/wrap behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fano_sym_reader;

    localparam int SW  = 3;
    localparam int MW  = 6;
    localparam int BI  = 4;
    localparam int FL  = 8;
    localparam int IW  = 3;
    localparam int SMW = 5;
    localparam int SBI = 30;
    localparam int SFL = 2;
    localparam int SIW = 1;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    // main instance
    logic              Start = 1'b0;
    logic              Busy, Done, rdRe, rdEmpty, oValid, oLast;
    logic              oReady = 1'b1;
    logic [2*SW-1:0]   rdData;
    logic [4*MW-1:0]   oBm;
    logic [IW-1:0]     oIdx;

    // narrow-metric instance
    logic              Start_s = 1'b0;
    logic              Busy_s, Done_s, rdRe_s, oValid_s, oLast_s;
    logic              rdEmpty_s = 1'b0;
    logic              oReady_s = 1'b1;
    logic [2*SW-1:0]   rdData_s = '0;
    logic [4*SMW-1:0]  oBm_s;
    logic [SIW-1:0]    oIdx_s;

    fano_sym_reader #(.SOFT_W(SW), .METRIC_W(MW), .BIAS(BI), .FRAME_LEN(FL)) u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .Done(Done),
        .rdData(rdData), .rdRe(rdRe), .rdEmpty(rdEmpty),
        .oValid(oValid), .oReady(oReady), .oBm(oBm), .oIdx(oIdx), .oLast(oLast)
    );

    fano_sym_reader #(.SOFT_W(SW), .METRIC_W(SMW), .BIAS(SBI), .FRAME_LEN(SFL)) u_dut_sat (
        .Clk(Clk), .Rst(Rst), .Start(Start_s), .Busy(Busy_s), .Done(Done_s),
        .rdData(rdData_s), .rdRe(rdRe_s), .rdEmpty(rdEmpty_s),
        .oValid(oValid_s), .oReady(oReady_s), .oBm(oBm_s), .oIdx(oIdx_s), .oLast(oLast_s)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference metric for one hypothesis, returned as a signed integer
    function automatic int bm_ref(input int s0, input int s1, input int k,
                                  input int bias, input int sw, input int mw);
        int mx, d0, d1, full, half, m;
        mx   = (1 << sw) - 1;
        d0   = ((k / 2) % 2 == 1) ? (mx - s0) : s0;
        d1   = ((k % 2) == 1) ? (mx - s1) : s1;
        full = bias - d0 - d1;
        half = 1 << (mw - 1);
`ifdef FANO_SYM_READER_SAT_EN
        m = full;
        if (m > half - 1) m = half - 1;
        if (m < -half)    m = -half;
`else
        m = full & ((1 << mw) - 1);
        if (m >= half) m = m - (1 << mw);
`endif
        return m;
    endfunction

    function automatic logic [4*MW-1:0] make_bm(input logic [2*SW-1:0] p);
        logic [4*MW-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k*MW +: MW] = MW'(bm_ref(int'(p[2*SW-1:SW]), int'(p[SW-1:0]), k, BI, SW, MW));
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // FIFO model (non-FWFT, one-cycle read latency) and scoreboard push
    // ------------------------------------------------------------------
    typedef struct {
        logic [4*MW-1:0] bm;
        int              idx;
        logic            last;
    } exp_t;

    logic [2*SW-1:0] fifo_mem [0:255];
    int              wr_ptr = 0;
    int              rd_ptr = 0;
    logic            force_empty = 1'b0;
    exp_t            exp_q [$];
    int              tb_idx = 0;

    assign rdEmpty = (wr_ptr == rd_ptr) | force_empty;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_ptr <= 0;
            rdData <= '0;
            tb_idx <= 0;
            exp_q.delete();
        end else if (rdRe) begin
            exp_q.push_back('{bm: make_bm(fifo_mem[rd_ptr % 256]), idx: tb_idx,
                              last: (tb_idx == FL - 1)});
            rdData <= fifo_mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
            tb_idx <= (tb_idx + 1) % FL;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: scoreboard compare on every accepted entry
    // ------------------------------------------------------------------
    int              cyc = 0;
    int              n_rd = 0;
    int              n_acc = 0;
    int              n_done = 0;
    int              done_cyc = 0;
    int              rd_cyc  [0:1023];
    int              pop_cyc [0:1023];
    logic [4*MW-1:0] pop_bm  [0:1023];
    int              pop_idx [0:1023];
    exp_t            e;
    logic            sat_seen = 1'b0;
    logic [4*SMW-1:0] sat_bm = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Rst) begin
            if (rdRe) begin
                rd_cyc[n_rd % 1024] = cyc;
                n_rd++;
            end
            if (oValid && oReady) begin
                check_val("sb_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("bm",   oBm,   e.bm);
                    check_val("idx",  oIdx,  e.idx);
                    check_val("last", oLast, e.last);
                    check_val("done", Done,  e.last);
                end
                pop_cyc[n_acc % 1024] = cyc;
                pop_bm[n_acc % 1024]  = oBm;
                pop_idx[n_acc % 1024] = int'(oIdx);
                n_acc++;
            end else if (Done) begin
                check_val("done_without_accept", Done, 0);
            end
            if (Done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (oValid_s && !sat_seen) begin
                sat_bm   = oBm_s;
                sat_seen = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_pairs(input int n, input bit first_special);
        for (int i = 0; i < n; i++) begin
            if (i == 0 && first_special) fifo_mem[wr_ptr % 256] = 6'o07; // sym0=0, sym1=7
            else                         fifo_mem[wr_ptr % 256] = 6'($urandom_range(0, 63));
            wr_ptr++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int start_cyc);
        Start     = 1'b1;
        start_cyc = cyc;
        tick(1);
        Start     = 1'b0;
    endtask

    task automatic wait_done(input int base, input int lim);
        for (int i = 0; i < lim && n_done == base; i++) tick(1);
        tick(3);
        check_val("frame_done_once", n_done - base, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},   Busy,   0);
        check_val({tag, "_done"},   Done,   0);
        check_val({tag, "_rdre"},   rdRe,   0);
        check_val({tag, "_valid"},  oValid, 0);
        check_val({tag, "_last"},   oLast,  0);
        check_val({tag, "_bm"},     oBm,    0);
        check_val({tag, "_idx"},    oIdx,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [4*MW-1:0] c_BM0;
    int start_cyc, base_rd, base_acc, base_done, snap, snap_idx;
    logic [4*MW-1:0] snap_bm;

    initial begin
        c_BM0 = {6'd61, 6'd54, 6'd4, 6'd61};   // k3..k0 = -3, -10, 4, -3

        // reset state
        tick(3);
        check_reset_outputs("reset");
        Rst = 1'b1;
        tick(2);

        // frame 1: full throughput, first pair (0,7)
        push_pairs(FL, 1'b1);
        base_rd = n_rd; base_acc = n_acc; base_done = n_done;
        Start_s = 1'b1;
        pulse_start(start_cyc);
        Start_s = 1'b0;
        check_val("busy_after_start", Busy, 1);
        wait_done(base_done, 40);
        check_val("f1_done_latency", done_cyc - start_cyc, FL + 2);
        check_val("f1_reads",        n_rd - base_rd, FL);
        check_val("f1_first_rd",     rd_cyc[base_rd] - start_cyc, 1);
        check_val("f1_rd_span",      rd_cyc[base_rd + FL - 1] - rd_cyc[base_rd], FL - 1);
        check_val("f1_valid_lat",    pop_cyc[base_acc] - rd_cyc[base_rd], 2);
        check_val("f1_pop_span",     pop_cyc[base_acc + FL - 1] - pop_cyc[base_acc], FL - 1);
        check_val("f1_bm_pair0",     pop_bm[base_acc], c_BM0);
        check_val("f1_idx0",         pop_idx[base_acc], 0);
        check_val("f1_busy_end",     Busy, 0);

        // narrow-metric instance, pair (0,0)
        check_val("sat_seen", sat_seen, 1);
        for (int k = 0; k < 4; k++)
            check_val("sat_bm", int'($signed(sat_bm[k*SMW +: SMW])), bm_ref(0, 0, k, SBI, SW, SMW));

        // frame 2: backpressure for 20 cycles
        push_pairs(FL, 1'b0);
        base_rd = n_rd; base_acc = n_acc; base_done = n_done;
        pulse_start(start_cyc);
        tick(3);
        oReady = 1'b0;
        tick(3);
        snap     = n_rd;
        snap_bm  = oBm;
        snap_idx = int'(oIdx);
        tick(17);
        check_val("bp_no_reads",    n_rd - snap, 0);
        check_val("bp_buffered",    n_rd - n_acc, 2);
        check_val("bp_valid",       oValid, 1);
        check_val("bp_rdre_low",    rdRe, 0);
        check_val("bp_hold_bm",     oBm, snap_bm);
        check_val("bp_hold_idx",    oIdx, snap_idx);
        oReady = 1'b1;
        wait_done(base_done, 40);
        check_val("f2_reads",   n_rd - base_rd, FL);
        check_val("f2_accepts", n_acc - base_acc, FL);

        // frame 3: FIFO-empty stall with Start pulsed while busy
        push_pairs(FL, 1'b0);
        base_rd = n_rd; base_acc = n_acc; base_done = n_done;
        pulse_start(start_cyc);
        tick(2);
        force_empty = 1'b1;
        snap = n_rd;
        tick(2);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(2);
        check_val("stall_no_reads", n_rd - snap, 0);
        check_val("stall_busy",     Busy, 1);
        force_empty = 1'b0;
        wait_done(base_done, 40);
        check_val("f3_accepts", n_acc - base_acc, FL);
        snap = n_rd;
        tick(10);
        check_val("f3_no_restart_busy",  Busy, 0);
        check_val("f3_no_restart_reads", n_rd - snap, 0);
        check_val("f3_fifo_drained",     wr_ptr - rd_ptr, 0);

        // frame 4: asynchronous reset mid-frame, then a clean frame
        push_pairs(FL, 1'b0);
        base_acc = n_acc;
        pulse_start(start_cyc);
        for (int i = 0; i < 40 && (n_acc - base_acc) < 4; i++) tick(1);
        check_val("rst_reached_pair3", (n_acc - base_acc >= 4) ? 1 : 0, 1);
        #2;
        Rst    = 1'b0;
        wr_ptr = 0;
        #1;
        check_reset_outputs("async_rst");
        tick(2);
        Rst = 1'b1;
        tick(1);
        push_pairs(FL, 1'b0);
        base_rd = n_rd; base_acc = n_acc; base_done = n_done;
        pulse_start(start_cyc);
        wait_done(base_done, 40);
        check_val("f4_first_idx", pop_idx[base_acc], 0);
        check_val("f4_accepts",   n_acc - base_acc, FL);
        check_val("sb_empty_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fano_sym_reader.md
# fano_sym_reader

Frame-oriented reader between the soft-symbol FIFO and the Fano decoder core. It pulls rate-1/2 soft-symbol pairs from the non-FWFT FIFO read port, which has one-cycle read latency. For each pair it computes the four branch metrics, buffers them in a 2-entry output buffer, and presents them to the decoder over a valid/ready handshake with pair index and last-of-frame flag. A Start/Busy/Done FSM bounds each frame to `FRAME_LEN` pairs.

## Interface
Parameters:
- `SOFT_W`, 3: soft symbol width, offset-binary (0 = strong '0', `2^SOFT_W-1` = strong '1').
- `METRIC_W`, 6: signed branch-metric width.
- `BIAS`, 4: per-branch metric bias, non-negative integer.
- `FRAME_LEN`, 64: symbol pairs per frame, ≥2.
- `IDX_W`, `$clog2(FRAME_LEN)`: pair index width.

Ports:
- `Clk` in 1: clock; all logic on rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `Start` in 1: one-cycle frame start; honoured only in IDLE.
- `Busy` out 1: high in RUN and DRAIN.
- `Done` out 1: one-cycle pulse when the last pair is accepted.
- `rdData` in `2*SOFT_W`: FIFO read data; `[2*SOFT_W-1:SOFT_W]` = sym0 (G1), `[SOFT_W-1:0]` = sym1 (G2).
- `rdRe` out 1: FIFO read enable.
- `rdEmpty` in 1: FIFO empty.
- `oValid` out 1: output entry valid.
- `oReady` in 1: decoder accepts entry.
- `oBm` out `4*METRIC_W`: `oBm[k*METRIC_W +: METRIC_W]` = metric for hypothesis k = {c0,c1}.
- `oIdx` out `IDX_W`: pair index within the frame, 0..`FRAME_LEN-1`.
- `oLast` out 1: entry is pair `FRAME_LEN-1`.

## Operation
FSM states:
- IDLE
  - Start → RUN.
  - Request counter `req_cnt` and accept counter `acc_cnt` cleared.
- RUN
  - Issue reads until `req_cnt == FRAME_LEN`, then → DRAIN.
- DRAIN
  - No reads issued.
  - When the entry with `oLast` is accepted (`oValid & oReady`): pulse `Done` and → IDLE.
  - If the last acceptance occurs while still in RUN, go RUN → IDLE directly, with `Done` pulsed in the same way.

Read issue:
- `rdRe = RUN & ~rdEmpty & (req_cnt < FRAME_LEN) & (occ + infl - pop < 2)`.
- `occ` is buffer occupancy (0..2).
- `infl` is a registered flag set by the previous cycle's `rdRe`.
- `pop = oValid & oReady`.
- Each `rdRe` increments `req_cnt`.
- The buffer never overflows; no FIFO data is dropped.

Capture:
- In the cycle after `rdRe` (`infl = 1`), compute the metrics from `rdData`.
- Write metrics, `oIdx = acc_cnt + occ_pending`, and `oLast` into the buffer tail.
- Indices are assigned in order from a separate write-index counter.

Metric arithmetic:
- `MAX = 2^SOFT_W-1`.
- `dist(s,b) = b ? MAX-s : s`.
- `bm[k] = BIAS - dist(sym0,c0) - dist(sym1,c1)`.
- Computed at 32-bit signed, then reduced to `METRIC_W` (see Configuration).

Output:
- Buffer is FIFO-ordered. Head drives `oBm`/`oIdx`/`oLast`.
- `oValid = (occ != 0)`.
- Push and pop in the same cycle are legal at any occupancy, including occ = 2 with pop.
- `Start` in RUN or DRAIN is ignored.
- `rdEmpty` high mid-frame stalls reads only; the output is unaffected.

## Timing
- Reset values:
  - State IDLE.
  - `Busy`, `Done`, `rdRe`, `oValid`, `oLast` = 0.
  - `oBm`, `oIdx` = 0.
  - All counters 0.
  - `infl` = 0.
- Start at cycle t → `Busy` at t+1. First `rdRe` possible at t+1.
- `rdRe` at t → `rdData` valid at t+1 → `oValid` at t+2 (latency 2).
- With FIFO non-empty and `oReady` held 1: one read and one acceptance per cycle.
- Frame of N pairs: `Done` at cycle t+N+2.
- `oReady` low: at most 2 reads outstanding; `rdRe` drops until a pop.
- Outputs hold stable while `oValid & ~oReady`.
- Reset mid-frame:
  - Immediate return to reset values.
  - In-flight FIFO data is discarded.
  - The FIFO is reset by its own reset.

## Configuration
- `FANO_SYM_READER_SAT_EN` defined: `bm` is clamped to [`-2^(METRIC_W-1)`, `2^(METRIC_W-1)-1`].
- Macro undefined: `bm` is truncated to its `METRIC_W` LSBs (two's-complement wrap). The parameterisation must avoid overflow.

## Test plan
- Metric values: `SOFT_W=3`, `BIAS=4`, `METRIC_W=6`, pair sym0=0, sym1=7 → `oBm` k0=-3, k1=4, k2=-10, k3=-3, `oIdx=0`, with `oValid` 2 cycles after `rdRe`.
- Saturation: `BIAS=30`, `METRIC_W=5`, pair (0,0).
  - k0 = 15 with `FANO_SYM_READER_SAT_EN`.
  - k0 = -2 without it.
- Full throughput: `FRAME_LEN=8`, FIFO prefilled with 8 pairs, `oReady=1`.
  - 8 consecutive `rdRe` cycles.
  - `oIdx` 0..7 on consecutive cycles.
  - `oLast` only at idx 7.
  - `Done` one cycle, 10 cycles after Start.
- Backpressure: `oReady=0` for 20 cycles mid-frame.
  - Exactly 2 entries buffered, `rdRe` held 0.
  - After release, no loss or duplication; order preserved.
- Empty stall / Start ignored: `rdEmpty=1` for 5 cycles mid-frame, with Start pulsed while Busy.
  - No `rdRe` during the stall.
  - Frame completes with `FRAME_LEN` pairs; no second frame starts.
- Async reset: assert `Rst` low at pair 3 of a frame, then deassert and Start again.
  - All outputs 0 immediately.
  - New frame begins at `oIdx=0`.
